// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts accepted bits into a W-bit window and compares it against a masked pattern.
// Latency: match, win, win_valid and match_cnt all update on the edge that accepts the completing bit.
// Backpressure: none; one bit is accepted on every cycle with in_valid high.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid, in_bit      qualified serial input; a new bit enters at the window LSB
//   pattern, care_mask    reference pattern and per-bit compare enable (0 = don't care)
//   overlap               1 = every accepted bit after the first full window may hit,
//                         0 = W fresh bits are needed after each hit
//   clear                 synchronous flush of the window, fill state, counter and flags
//   win, win_valid        window contents, and a flag showing that W bits are held since the last restart
//   match                 one-cycle registered hit pulse
//   match_cnt, cnt_sat    saturating hit counter and sticky saturation flag
// W must be at least 2.
module serial_pattern_detector #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [W-1:0]     pattern,
    input  logic [W-1:0]     care_mask,
    input  logic             overlap,
    input  logic             clear,
    output logic [W-1:0]     win,
    output logic             win_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(W);
    localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     win_q, win_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // The next window and next fill count are computed unconditionally, and the
    // compare runs on the next window, so a hit is registered on the same edge
    // that accepts the completing bit.
    logic [W-1:0]  win_next;
    logic [FW-1:0] fill_next;
    logic          hit;

    always_comb begin
        win_next  = {win_q[W-2:0], in_bit};
        fill_next = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_ONE;
        hit       = (fill_next == FILL_FULL) &&
                    (((win_next ^ pattern) & care_mask) == '0);
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        if (clear) begin
            // clear wins over a simultaneous in_valid; that bit is dropped.
            state_d = FILL;
            win_d   = '0;
            fill_d  = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else if (in_valid) begin
            win_d   = win_next;
            fill_d  = fill_next;
            state_d = (fill_next == FILL_FULL) ? ARMED : FILL;
            if (hit) begin
                match_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (cnt_d == CNT_MAX) begin
                    sat_d = 1'b1;
                end
                // Non-overlapping mode: the window keeps the new bit for visibility,
                // but the fill restarts, so the next hit needs W new bits.
                if (!overlap) begin
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            win_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign win       = win_q;
    assign win_valid = (state_q == ARMED);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule
